clm_decoder: RTL and testbench



---
 rtl/clm_decoder_pkg.sv | 14 +
 rtl/clm_decoder_if.sv | 25 ++
 rtl/clm_decoder_reduce_step.sv | 25 ++
 rtl/clm_decoder.sv | 78 +++++++
 tb/tb_clm_decoder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/clm_decoder_pkg.sv
// rtl/clm_decoder_pkg.sv - shared types and constants for the CLM-to-GF(2^8) decoder
package clm_decoder_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [8:0] AES_POLY = 9'h11B;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } dec_state_t;

endpackage

// File: rtl/clm_decoder_if.sv
// rtl/clm_decoder_if.sv - input element stream and output byte stream of the decoder
interface clm_decoder_if
  import clm_decoder_pkg::*;
#(
  parameter int d = 8
);

  logic           in_valid;
  logic           in_ready;
  logic [7+d:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  byte_t          out_byte;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_byte
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_byte
  );

endinterface

// File: rtl/clm_decoder_reduce_step.sv
// rtl/clm_decoder_reduce_step.sv - one bit-serial reduction step: clear rem[cnt] with a shifted POLY
module clm_decoder_reduce_step
  import clm_decoder_pkg::*;
#(
  parameter int          d    = 8,
  parameter logic [8:0]  POLY = AES_POLY,
  localparam int         W    = 8 + d,
  localparam int         CW   = $clog2(W)
) (
  input  logic [W-1:0]  rem,
  input  logic [CW-1:0] cnt,
  output logic [W-1:0]  nxt
);

  logic [W-1:0]  poly_ext;
  logic [CW-1:0] shamt;

  // cnt never exceeds 7+d, so the shifted POLY always fits in W bits
  always_comb begin
    poly_ext = W'(POLY);
    shamt    = cnt - CW'(8);
    nxt      = rem[cnt] ? (rem ^ (poly_ext << shamt)) : rem;
  end

endmodule

// File: rtl/clm_decoder.sv
// rtl/clm_decoder.sv - serial reducer from the (8+d)-bit CLM domain to a GF(2^8) byte
module clm_decoder
  import clm_decoder_pkg::*;
#(
  parameter int          d    = 8,
  parameter logic [8:0]  POLY = AES_POLY
) (
  input  logic            clk,
  input  logic            rst_n,
  clm_decoder_if.slave    bus,
  output logic            busy
);

  localparam int W  = 8 + d;
  localparam int CW = $clog2(W);

  dec_state_t    state;
  logic [W-1:0]  rem;
  logic [W-1:0]  nxt;
  logic [CW-1:0] cnt;

  clm_decoder_reduce_step #(
    .d    (d),
    .POLY (POLY)
  ) u_step (
    .rem (rem),
    .cnt (cnt),
    .nxt (nxt)
  );

  // all handshake outputs are registered so none depends combinationally on an input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rem           <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_byte  <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rem          <= bus.in_data;
            cnt          <= CW'(7 + d);
            state        <= REDUCE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
          end
        end
        REDUCE: begin
          rem <= nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(8)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_byte  <= nxt[7:0];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_byte  <= '0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_rem_reduced: assert property (@(posedge clk) disable iff (!rst_n)
    (state == DONE) |-> (rem[W-1:8] == '0));

endmodule

// File: tb/tb_clm_decoder.sv
// tb/tb_clm_decoder.sv - directed and randomized self-checking bench for clm_decoder (d=8)
module tb_clm_decoder;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  clm_decoder_if #(.d(D)) bus ();

  clm_decoder #(.d(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] clmul(input logic [7:0] a, input logic [8:0] b);
    logic [15:0] acc = '0;
    for (int i = 0; i < 8; i++)
      if (a[i]) acc = acc ^ (16'(b) << i);
    return acc;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  // one full transaction; lat counts clock edges from the input handshake to out_valid
  task automatic decode(input logic [15:0] data, output logic [7:0] res, output int lat,
                        output logic leak);
    int guard = 0;
    leak = 1'b0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.out_byte !== 8'h00) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("decode_timeout", 32'(lat), 32'd8);
    res = bus.out_byte;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  res;
    logic [7:0]  held;
    logic        leak;
    int          lat;
    int          lat_bad;
    logic [7:0]  x, y, r1, r2;
    logic [15:0] a, b;
    int          bad_lin, bad_mul;

    vecs[0] = '{16'h0001, 8'h01};
    vecs[1] = '{16'h011B, 8'h00};
    vecs[2] = '{16'h0100, 8'h1B};
    vecs[3] = '{16'h8000, 8'h2F};  // x^15 mod P
    vecs[4] = '{16'h0000, 8'h00};
    vecs[5] = '{16'h00AB, 8'hAB};
    vecs[6] = '{16'h0200, 8'h36};
    vecs[7] = '{16'h4000, 8'h9A};
    vecs[8] = '{16'hFFFF, 8'h35};
    vecs[9] = '{16'h1000, 8'hAB};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_byte", 32'(bus.out_byte), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      decode(vecs[i].din, res, lat, leak);
      check($sformatf("vec%0d_byte", i), 32'(res), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(D));
      check($sformatf("vec%0d_no_leak", i), 32'(leak), 32'd0);
    end

    // backpressure, with in_valid held high during REDUCE and DONE
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h8000;
    @(negedge clk);
    bus.in_data  = 16'hFFFF;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(D));
    held = bus.out_byte;
    check("bp_byte", 32'(held), 32'h2F);
    lat_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_byte !== held || bus.in_ready !== 1'b0 || busy !== 1'b1)
        lat_bad++;
      @(negedge clk);
    end
    check("bp_hold_stable", 32'(lat_bad), 32'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_out_byte", 32'(bus.out_byte), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);

    // reset in the fourth REDUCE cycle
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h8000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_out_byte", 32'(bus.out_byte), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    decode(16'h0100, res, lat, leak);
    check("rst_mid_redecode", 32'(res), 32'h1B);

    // linearity of encoded elements and decode of carry-less products
    bad_lin = 0;
    bad_mul = 0;
    for (int i = 0; i < 150; i++) begin
      x  = 8'($urandom_range(0, 255));
      y  = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      a  = 16'(x) ^ clmul(r1, 9'h11B);
      b  = 16'(y) ^ clmul(r2, 9'h11B);
      decode(a ^ b, res, lat, leak);
      if (res !== (x ^ y) || lat != D) begin
        bad_lin++;
        if (bad_lin == 1) check("rand_linear", 32'(res), 32'(x ^ y));
      end
      decode(clmul(x, {1'b0, y}), res, lat, leak);
      if (res !== gf_mul(x, y) || lat != D) begin
        bad_mul++;
        if (bad_mul == 1) check("rand_product", 32'(res), 32'(gf_mul(x, y)));
      end
    end
    check("rand_linear_errors", 32'(bad_lin), 32'd0);
    check("rand_product_errors", 32'(bad_mul), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
